// File: rtl/if_fetch_unit.sv
// if_fetch_unit: decoupled instruction-fetch stage for the SRAM-like bus.
// Requests are issued ahead of responses, with up to MAX_OUTSTANDING of them
// in flight. Responses return in request order and are matched against a PC
// queue. They are then staged in an IBUF_DEPTH-entry buffer toward ID.
// A redirect (flush or taken branch) cancels in-flight responses by count.
// A misaligned fetch PC produces one ADEF-tagged entry and then stalls
// fetching until the next redirect.
// Optional feature macro: IF_BYPASS_EN. When it is defined, a live response
// that arrives while the buffer is empty is presented to ID in the same cycle.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        id_allowin,
  input  logic [32:0] id_to_if_bus,
  output logic        if_to_id_valid,
  output logic [64:0] if_to_id_bus,
  input  logic        flush,
  input  logic [31:0] excep_entry
);

  localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int CW  = $clog2(IBUF_DEPTH) + 1;
  localparam int IPW = $clog2(IBUF_DEPTH);
  // The PC queue keeps at least two slots so its pointer is never zero bits wide.
  localparam int QPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int QD  = 1 << QPW;
  localparam logic [OW-1:0] OS_MAX  = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] IB_FULL = CW'(IBUF_DEPTH);

  logic [31:0]    fetch_pc;
  logic           adef_stall;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  outstanding_nxt;
  logic [OW-1:0]  cancel_cnt;

  logic [31:0]    pcq_mem [QD];
  logic [QPW-1:0] pcq_head;
  logic [QPW-1:0] pcq_tail;

  logic [64:0]    ibuf_mem [IBUF_DEPTH];
  logic [IPW-1:0] ibuf_head;
  logic [IPW-1:0] ibuf_tail;
  logic [CW-1:0]  ibuf_count;

  logic           redirect;
  logic [31:0]    redirect_pc;
  logic           handshake;
  logic           resp_valid;
  logic           resp_live;
  logic [64:0]    resp_entry;
  logic           ibuf_empty;
  logic           ibuf_full;
  logic           fetch_room;
  logic           adef_push;
  logic           bypass_sel;
  logic           ibuf_push;
  logic           ibuf_pop;
  logic [64:0]    ibuf_wdata;

  // Fixed bus attributes: word-sized reads only.
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'h0;
  assign inst_addr  = fetch_pc;

  // Flush takes priority over a branch that is taken in the same cycle.
  assign redirect    = flush | id_to_if_bus[32];
  assign redirect_pc = flush ? excep_entry : id_to_if_bus[31:0];

  assign ibuf_empty = (ibuf_count == '0);
  assign ibuf_full  = (ibuf_count == IB_FULL);
  // Buffer space is reserved when a request issues, so a response always has a slot.
  assign fetch_room = (32'(ibuf_count) + 32'(outstanding)) < 32'(IBUF_DEPTH);

  assign inst_req  = ~reset & ~redirect & ~adef_stall & (fetch_pc[1:0] == 2'b00)
                   & (outstanding < OS_MAX) & fetch_room;
  assign handshake = inst_req & inst_addr_ok;

  // A response with nothing outstanding is a bus violation and is ignored.
  assign resp_valid = inst_data_ok & (outstanding != '0);
  assign resp_live  = resp_valid & (cancel_cnt == '0);
  assign resp_entry = {inst_rdata, pcq_mem[pcq_head], 1'b0};

  assign adef_push = ~redirect & ~adef_stall & (fetch_pc[1:0] != 2'b00)
                   & (outstanding == '0) & (cancel_cnt == '0) & ~ibuf_full;

`ifdef IF_BYPASS_EN
  assign bypass_sel = ibuf_empty & resp_live;
`else
  assign bypass_sel = 1'b0;
`endif

  assign if_to_id_valid = (~ibuf_empty | bypass_sel) & ~redirect;
  assign if_to_id_bus   = bypass_sel ? resp_entry : ibuf_mem[ibuf_head];
  assign ibuf_pop       = if_to_id_valid & id_allowin & ~bypass_sel;

  assign outstanding_nxt = outstanding + OW'(handshake) - OW'(resp_valid);

  // Pick what enters the instruction buffer this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    ibuf_push  = 1'b0;
    ibuf_wdata = resp_entry;
    if (adef_push) begin
      ibuf_push  = 1'b1;
      ibuf_wdata = {32'h0, fetch_pc, 1'b1};
    end else if (resp_live && !(bypass_sel && id_allowin)) begin
      ibuf_push = 1'b1;
    end
  end

  // Control state: fetch PC, counters, queue pointers and redirect handling.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments, so every read in this block sees the pre-edge value.
    if (reset) begin
      fetch_pc    <= RESET_PC;
      adef_stall  <= 1'b0;
      outstanding <= '0;
      cancel_cnt  <= '0;
      pcq_head    <= '0;
      pcq_tail    <= '0;
      ibuf_head   <= '0;
      ibuf_tail   <= '0;
      ibuf_count  <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        // Every response still owed after this edge belongs to the old path.
        // Cancelled responses never touch the PC queue, so it can restart empty.
        fetch_pc   <= redirect_pc;
        cancel_cnt <= outstanding_nxt;
        adef_stall <= 1'b0;
        pcq_head   <= '0;
        pcq_tail   <= '0;
        ibuf_head  <= '0;
        ibuf_tail  <= '0;
        ibuf_count <= '0;
      end else begin
        if (handshake) begin
          fetch_pc <= fetch_pc + 32'd4;
          pcq_tail <= pcq_tail + QPW'(1);
        end
        if (resp_live) pcq_head <= pcq_head + QPW'(1);
        if (resp_valid && !resp_live) cancel_cnt <= cancel_cnt - OW'(1);
        if (adef_push) adef_stall <= 1'b1;
        if (ibuf_push) ibuf_tail <= ibuf_tail + IPW'(1);
        if (ibuf_pop)  ibuf_head <= ibuf_head + IPW'(1);
        ibuf_count <= ibuf_count + CW'(ibuf_push) - CW'(ibuf_pop);
      end
    end
  end

  // Queue storage: writes only.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; the pointers and counts define which entries are valid.
    if (handshake) pcq_mem[pcq_tail]   <= fetch_pc;
    if (ibuf_push) ibuf_mem[ibuf_tail] <= ibuf_wdata;
  end

  // Simulation check for a response that arrives with no request outstanding.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(inst_data_ok && (outstanding == '0)))
        else $error("if_fetch_unit: data_ok with no outstanding request");
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit with the default parameters
// (IBUF_DEPTH 4, MAX_OUTSTANDING 2). A bus slave model inside tick() returns
// ~addr as the instruction, one cycle after each accepted request, while
// resp_en is set. Inputs change on the falling edge and outputs are checked there.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_allowin;
  logic [32:0] id_to_if_bus;
  logic        if_to_id_valid;
  logic [64:0] if_to_id_bus;
  logic        flush;
  logic [31:0] excep_entry;

  int tests = 0;
  int fails = 0;

  logic        resp_en;
  logic [31:0] pending [$];
  logic [31:0] hs_log  [$];
  logic [64:0] id_log  [$];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .inst_req       (inst_req),
    .inst_wr        (inst_wr),
    .inst_size      (inst_size),
    .inst_addr      (inst_addr),
    .inst_wdata     (inst_wdata),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .id_allowin     (id_allowin),
    .id_to_if_bus   (id_to_if_bus),
    .if_to_id_valid (if_to_id_valid),
    .if_to_id_bus   (if_to_id_bus),
    .flush          (flush),
    .excep_entry    (excep_entry)
  );

  function automatic logic [64:0] ent(input logic [31:0] pc);
    return {~pc, pc, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One clock cycle. First record this cycle's handshake and ID pop.
  // Then, after the edge, drop the redirect pulses and drive the bus response.
  task automatic tick();
    if (inst_req && inst_addr_ok) begin
      pending.push_back(inst_addr);
      hs_log.push_back(inst_addr);
    end
    if (if_to_id_valid && id_allowin) id_log.push_back(if_to_id_bus);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    id_to_if_bus = '0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    if (reset) pending.delete();
    else if (resp_en && pending.size() > 0) begin
      inst_data_ok = 1'b1;
      inst_rdata   = ~pending.pop_front();
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    resp_en      = 1'b1;
    id_allowin   = 1'b1;
    inst_addr_ok = 1'b1;
    ticks(2);
    reset = 1'b0;
    hs_log.delete();
    id_log.delete();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    id_allowin   = 1'b1;
    id_to_if_bus = '0;
    flush        = 1'b0;
    excep_entry  = '0;
    resp_en      = 1'b1;
    @(negedge clk);
    ticks(2);

    // Reset state and fixed bus fields.
    check("rst_req",   inst_req, 0);
    check("rst_valid", if_to_id_valid, 0);
    check("rst_wr",    inst_wr, 0);
    check("rst_size",  inst_size, 2'b10);
    check("rst_wdata", inst_wdata, 0);

    // 1: streaming fetch after reset release.
    reset = 1'b0;
    hs_log.delete();
    id_log.delete();
    #1;
    check("t1_req0",  inst_req, 1);
    check("t1_addr0", inst_addr, 32'h1c000000);
    tick();
    check("t1_addr1", inst_addr, 32'h1c000004);
`ifdef IF_BYPASS_EN
    // 6: with the bypass, the response is visible in its own data_ok cycle.
    check("t6_valid_same", if_to_id_valid, 1);
    check("t6_bus_same",   if_to_id_bus, ent(32'h1c000000));
`else
    // 6: without the bypass, nothing is visible in the data_ok cycle.
    check("t6_valid_same", if_to_id_valid, 0);
`endif
    tick();
    check("t1_valid2", if_to_id_valid, 1);
`ifdef IF_BYPASS_EN
    check("t1_bus2", if_to_id_bus, ent(32'h1c000004));
`else
    check("t1_bus2", if_to_id_bus, ent(32'h1c000000));
`endif
    ticks(4);
    check("t1_idcnt", id_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_id%0d", i), id_log[i], ent(32'h1c000000 + 32'(4 * i)));
    check("t1_hs3", hs_log[3], 32'h1c00000c);

    // 2: ID stalled. Buffer reservation caps the run at 4 requests.
    do_reset();
    id_allowin = 1'b0;
    #1;
    ticks(10);
    check("t2_hscnt",  hs_log.size(), 4);
    check("t2_hs3",    hs_log[3], 32'h1c00000c);
    check("t2_req",    inst_req, 0);
    check("t2_valid",  if_to_id_valid, 1);
    check("t2_head",   if_to_id_bus, ent(32'h1c000000));
    check("t2_nopop",  id_log.size(), 0);
    id_allowin = 1'b1;
    ticks(4);
    check("t2_idcnt", id_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_id%0d", i), id_log[i], ent(32'h1c000000 + 32'(4 * i)));
    check("t2_hs4", hs_log[4], 32'h1c000010);

    // 3: two requests in flight, then a taken branch cancels both responses.
    do_reset();
    resp_en = 1'b0;
    ticks(2);
    check("t3_cap_req", inst_req, 0);
    check("t3_hscnt",   hs_log.size(), 2);
    id_to_if_bus = {1'b1, 32'h1c000100};
    resp_en      = 1'b1;
    #1;
    check("t3_redir_valid", if_to_id_valid, 0);
    tick();
    check("t3_pc",       inst_addr, 32'h1c000100);
    check("t3_req_full", inst_req, 0);
    tick();
    check("t3_req_resume", inst_req, 1);
    ticks(4);
    check("t3_hs2",   hs_log[2], 32'h1c000100);
    check("t3_idcnt", id_log.size() >= 1, 1);
    check("t3_id0",   id_log[0], ent(32'h1c000100));

    // 4: flush and branch in the same cycle; the flush target wins.
    do_reset();
    flush        = 1'b1;
    excep_entry  = 32'h1c008000;
    id_to_if_bus = {1'b1, 32'h1c000200};
    #1;
    check("t4_req_redir", inst_req, 0);
    tick();
    check("t4_pc",  inst_addr, 32'h1c008000);
    check("t4_req", inst_req, 1);
    ticks(3);
    check("t4_id0", id_log[0], ent(32'h1c008000));

    // 5: misaligned branch target raises ADEF and stalls until a flush.
    do_reset();
    id_to_if_bus = {1'b1, 32'h1c000102};
    #1;
    tick();
    check("t5_pc",     inst_addr, 32'h1c000102);
    check("t5_req1",   inst_req, 0);
    check("t5_valid1", if_to_id_valid, 0);
    id_allowin = 1'b0;
    tick();
    check("t5_valid2", if_to_id_valid, 1);
    check("t5_adef",   if_to_id_bus, {32'h0, 32'h1c000102, 1'b1});
    ticks(5);
    check("t5_req_stall", inst_req, 0);
    check("t5_hold",      if_to_id_bus, {32'h0, 32'h1c000102, 1'b1});
    check("t5_nohs",      hs_log.size(), 0);
    id_allowin = 1'b1;
    ticks(4);
    check("t5_idcnt",    id_log.size(), 1);
    check("t5_valid_end", if_to_id_valid, 0);
    check("t5_req_end",   inst_req, 0);
    flush       = 1'b1;
    excep_entry = 32'h1c008000;
    #1;
    tick();
    check("t5_req_flush",  inst_req, 1);
    check("t5_addr_flush", inst_addr, 32'h1c008000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
